// File: rtl/demultiplexer_stream4_if.sv
// Handshake bundle for the 1-to-4 stream demultiplexer: one producer channel
// in, four registered consumer channels out.
`timescale 1ns/1ps
interface demultiplexer_stream4_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] in_data;
    logic [1:0]       in_sel;
    logic             in_valid;
    logic             in_ready;

    logic [WIDTH-1:0] out0_data;
    logic [WIDTH-1:0] out1_data;
    logic [WIDTH-1:0] out2_data;
    logic [WIDTH-1:0] out3_data;
    logic             out0_valid;
    logic             out1_valid;
    logic             out2_valid;
    logic             out3_valid;
    logic             out0_ready;
    logic             out1_ready;
    logic             out2_ready;
    logic             out3_ready;

    modport slave (
        input  in_data, in_sel, in_valid,
        output in_ready,
        output out0_data, out1_data, out2_data, out3_data,
        output out0_valid, out1_valid, out2_valid, out3_valid,
        input  out0_ready, out1_ready, out2_ready, out3_ready
    );

    modport master (
        output in_data, in_sel, in_valid,
        input  in_ready,
        input  out0_data, out1_data, out2_data, out3_data,
        input  out0_valid, out1_valid, out2_valid, out3_valid,
        output out0_ready, out1_ready, out2_ready, out3_ready
    );
endinterface

// File: rtl/demultiplexer_stream4.sv
// 1-to-4 valid/ready stream demultiplexer with one-entry holding register per
// output channel and a per-channel wrapping transfer counter.
`timescale 1ns/1ps
module demultiplexer_stream4 #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    demultiplexer_stream4_if.slave bus,
    input  logic                   cnt_clr,
    output logic [4*CNT_W-1:0]     cnt
);
    logic [WIDTH-1:0] r_data [4];
    logic [CNT_W-1:0] r_cnt  [4];
    logic [3:0]       r_valid;
    logic [3:0]       w_out_ready;
    logic [3:0]       w_load;
    logic             w_accept;

    assign w_out_ready = {bus.out3_ready, bus.out2_ready, bus.out1_ready, bus.out0_ready};

    // Ready looks only at the addressed channel's state, never at in_valid.
    assign bus.in_ready = rst_n && (!r_valid[bus.in_sel] || w_out_ready[bus.in_sel]);
    assign w_accept     = bus.in_valid && bus.in_ready;

    always_comb begin
        w_load              = '0;
        w_load[bus.in_sel]  = w_accept;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= '0;
            for (int unsigned k = 0; k < 4; k++) begin
                r_data[k] <= '0;
                r_cnt[k]  <= '0;
            end
        end else begin
            for (int unsigned k = 0; k < 4; k++) begin
                // A load wins over a drain so a channel can refill every cycle.
                if (w_load[k]) begin
                    r_data[k]  <= bus.in_data;
                    r_valid[k] <= 1'b1;
                end else if (w_out_ready[k]) begin
                    r_valid[k] <= 1'b0;
                end

                if (cnt_clr) begin
                    r_cnt[k] <= w_load[k] ? CNT_W'(1) : '0;
                end else if (w_load[k]) begin
                    r_cnt[k] <= r_cnt[k] + CNT_W'(1);
                end
            end
        end
    end

    assign bus.out0_data  = r_data[0];
    assign bus.out1_data  = r_data[1];
    assign bus.out2_data  = r_data[2];
    assign bus.out3_data  = r_data[3];
    assign bus.out0_valid = r_valid[0];
    assign bus.out1_valid = r_valid[1];
    assign bus.out2_valid = r_valid[2];
    assign bus.out3_valid = r_valid[3];

    always_comb begin
        cnt = '0;
        for (int unsigned k = 0; k < 4; k++) begin
            cnt[k*CNT_W +: CNT_W] = r_cnt[k];
        end
    end
endmodule

// File: tb/tb_demultiplexer_stream4.sv
// Scoreboard bench for demultiplexer_stream4: the driver queues each accepted
// word per channel, a negedge monitor pops and compares on every handshake.
`timescale 1ns/1ps
module tb_demultiplexer_stream4;
    localparam int W  = 32;
    localparam int CW = 4;

    logic          clk     = 1'b0;
    logic          rst_n   = 1'b0;
    logic          cnt_clr = 1'b0;
    logic [4*CW-1:0] cnt;

    int checks   = 0;
    int failures = 0;

    logic [W-1:0] q0[$];
    logic [W-1:0] q1[$];
    logic [W-1:0] q2[$];
    logic [W-1:0] q3[$];

    demultiplexer_stream4_if #(.WIDTH(W)) bus ();

    demultiplexer_stream4 #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (bus),
        .cnt_clr (cnt_clr),
        .cnt     (cnt)
    );

    always #5 clk = ~clk;

    logic [3:0] vld;
    assign vld = {bus.out3_valid, bus.out2_valid, bus.out1_valid, bus.out0_valid};

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [1:0] s, input logic [W-1:0] d);
        case (s)
            2'd0: q0.push_back(d);
            2'd1: q1.push_back(d);
            2'd2: q2.push_back(d);
            default: q3.push_back(d);
        endcase
    endtask

    function automatic int qtotal();
        return q0.size() + q1.size() + q2.size() + q3.size();
    endfunction

    task automatic mon(input int k, input logic [W-1:0] d);
        logic [W-1:0] e;
        logic         hit;
        e   = '0;
        hit = 1'b0;
        case (k)
            0: if (q0.size() > 0) begin e = q0.pop_front(); hit = 1'b1; end
            1: if (q1.size() > 0) begin e = q1.pop_front(); hit = 1'b1; end
            2: if (q2.size() > 0) begin e = q2.pop_front(); hit = 1'b1; end
            default: if (q3.size() > 0) begin e = q3.pop_front(); hit = 1'b1; end
        endcase
        checks++;
        if (!hit) begin
            failures++;
            $display("FAIL sb_ch%0d: got unexpected word 0x%0h required none", k, d);
        end else if (d !== e) begin
            failures++;
            $display("FAIL sb_ch%0d: got 0x%0h required 0x%0h", k, d, e);
        end
    endtask

    always @(negedge clk) begin
        if (bus.out0_valid && bus.out0_ready) mon(0, bus.out0_data);
        if (bus.out1_valid && bus.out1_ready) mon(1, bus.out1_data);
        if (bus.out2_valid && bus.out2_ready) mon(2, bus.out2_data);
        if (bus.out3_valid && bus.out3_ready) mon(3, bus.out3_data);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Leaves in_valid asserted so consecutive calls issue back-to-back words.
    task automatic send(input logic [1:0] s, input logic [W-1:0] d, output int stalls);
        int n;
        n = 0;
        bus.in_sel   = s;
        bus.in_data  = d;
        bus.in_valid = 1'b1;
        @(negedge clk);
        while (!bus.in_ready && n < 50) begin
            n++;
            @(negedge clk);
        end
        stalls = n;
        if (!bus.in_ready) begin
            checks++;
            failures++;
            $display("FAIL send_timeout: got no accept on ch%0d required accept within 50 cycles", s);
            bus.in_valid = 1'b0;
        end else begin
            push(s, d);
            tick();
        end
    endtask

    task automatic clear_cnt();
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        chk("cnt_clear", cnt, 0);
    endtask

    task automatic set_ready(input logic [3:0] r);
        {bus.out3_ready, bus.out2_ready, bus.out1_ready, bus.out0_ready} = r;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish required finish before 200us");
        $fatal(1, "watchdog");
    end

    initial begin
        int st;
        bus.in_data  = '0;
        bus.in_sel   = '0;
        bus.in_valid = 1'b0;
        set_ready(4'b0000);

        #12;
        chk("rst_in_ready", bus.in_ready, 0);
        chk("rst_valid", vld, 0);
        chk("rst_data", bus.out0_data | bus.out1_data | bus.out2_data | bus.out3_data, 0);
        chk("rst_cnt", cnt, 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // route sweep
        set_ready(4'b1111);
        for (int i = 0; i < 4; i++) begin
            send(2'(i), 32'hA000_0000 + 32'(i), st);
            chk("sweep_stall", st, 0);
            chk("sweep_valid", vld, 64'(1) << i);
        end
        chk("sweep_d3", bus.out3_data, 32'hA000_0003);
        bus.in_valid = 1'b0;
        tick();
        chk("sweep_pulse", vld, 0);
        chk("sweep_cnt", cnt, 16'h1111);
        clear_cnt();

        // backpressure on ch2
        set_ready(4'b1011);
        send(2'd2, 32'h1234_5678, st);
        bus.in_sel   = 2'd2;
        bus.in_data  = 32'hDEAD_BEEF;
        bus.in_valid = 1'b1;
        repeat (2) begin
            @(negedge clk);
            chk("bp_in_ready", bus.in_ready, 0);
            chk("bp_hold", bus.out2_data, 32'h1234_5678);
        end
        tick();
        set_ready(4'b1111);
        send(2'd2, 32'hDEAD_BEEF, st);
        chk("bp_stall_after", st, 0);
        chk("bp_new_valid", bus.out2_valid, 1);
        chk("bp_new_data", bus.out2_data, 32'hDEAD_BEEF);
        bus.in_valid = 1'b0;
        chk("bp_cnt", cnt, 16'h0200);
        tick();
        clear_cnt();

        // head-of-line: stalled ch1 blocks a following ch0 word
        set_ready(4'b1101);
        send(2'd1, 32'h1111_0001, st);
        bus.in_sel   = 2'd1;
        bus.in_data  = 32'h1111_0002;
        bus.in_valid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("hol_in_ready", bus.in_ready, 0);
            chk("hol_out0_idle", bus.out0_valid, 0);
            chk("hol_out1_hold", bus.out1_data, 32'h1111_0001);
        end
        tick();
        set_ready(4'b1111);
        send(2'd1, 32'h1111_0002, st);
        send(2'd0, 32'h0000_0C0C, st);
        chk("hol_out0_data", bus.out0_data, 32'h0000_0C0C);
        bus.in_valid = 1'b0;
        tick();
        tick();
        chk("hol_sb_empty", qtotal(), 0);
        chk("hol_cnt", cnt, 16'h0021);
        clear_cnt();

        // full throughput on ch3
        for (int i = 1; i <= 8; i++) begin
            send(2'd3, 32'(i), st);
            chk("tp_stall", st, 0);
            chk("tp_valid", bus.out3_valid, 1);
            chk("tp_data", bus.out3_data, 32'(i));
        end
        bus.in_valid = 1'b0;
        chk("tp_cnt", cnt, 16'h8000);
        tick();
        chk("tp_drained", bus.out3_valid, 0);
        clear_cnt();

        // counter wrap and clear coincident with accept
        for (int i = 0; i < 17; i++) begin
            send(2'd0, 32'h0500_0000 + 32'(i), st);
        end
        bus.in_valid = 1'b0;
        chk("wrap_cnt", cnt, 16'h0001);
        cnt_clr = 1'b1;
        send(2'd1, 32'h0000_C1C1, st);
        cnt_clr      = 1'b0;
        bus.in_valid = 1'b0;
        chk("clr_accept_cnt", cnt, 16'h0010);

        // async reset mid-stream
        set_ready(4'b1010);
        send(2'd0, 32'hAAAA_0000, st);
        send(2'd2, 32'hAAAA_0002, st);
        bus.in_valid = 1'b0;
        chk("ar_pre_valid", vld, 4'b0101);
        chk("ar_pre_cnt", cnt, 16'h0111);
        #2;
        bus.in_sel   = 2'd1;
        bus.in_valid = 1'b1;
        rst_n        = 1'b0;
        #1;
        chk("ar_valid", vld, 0);
        chk("ar_data", bus.out0_data | bus.out2_data, 0);
        chk("ar_cnt", cnt, 0);
        chk("ar_in_ready", bus.in_ready, 0);
        bus.in_valid = 1'b0;
        q0.delete();
        q2.delete();
        tick();
        chk("ar_hold_valid", vld, 0);
        @(negedge clk);
        rst_n = 1'b1;
        set_ready(4'b1111);
        tick();
        send(2'd2, 32'hBBBB_0002, st);
        chk("ar_resume_data", bus.out2_data, 32'hBBBB_0002);
        send(2'd1, 32'hBBBB_0001, st);
        bus.in_valid = 1'b0;
        chk("ar_resume_cnt", cnt, 16'h0110);
        repeat (3) tick();
        chk("final_sb_empty", qtotal(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
